// File: rtl/imm_split_seq.sv
`default_nettype none
// ============================================================================
// imm_split_seq : splits a 32-bit constant into the shortest (Imm16, EXTOp)
//                 word sequence that the EXT immediate extender rebuilds.
// Revision      : 1.0
// ============================================================================
module imm_split_seq #(
  parameter bit ENABLE_SIGNED = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_imm16,
  output logic [1:0]       out_extop,
  output logic             out_merge,
  output logic             out_last,
  output logic [CNT_W-1:0] words_emitted
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_emit1 = 2'd1;
  localparam logic [1:0] c_emit2 = 2'd2;

  localparam logic [1:0] c_cls_sgn = 2'd0;
  localparam logic [1:0] c_cls_zer = 2'd1;
  localparam logic [1:0] c_cls_hip = 2'd2;
  localparam logic [1:0] c_cls_two = 2'd3;

  localparam logic [1:0] c_ext_zero = 2'b00;
  localparam logic [1:0] c_ext_sign = 2'b01;
  localparam logic [1:0] c_ext_high = 2'b10;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [31:0]      r_v;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_cls;
  logic             w_sgn_fit;
  logic             w_hs_in;
  logic             w_hs_out;

  assign w_hs_in       = in_valid & in_ready;
  assign w_hs_out      = out_valid & out_ready;
  assign words_emitted = r_cnt;

  // A value fits the sign rule when bits 31..15 are all copies of one bit.
  assign w_sgn_fit = ENABLE_SIGNED && ((r_v[31:15] == '0) || (r_v[31:15] == '1));

  always_comb begin
    w_cls = c_cls_two;
    if (w_sgn_fit)
      w_cls = c_cls_sgn;
    else if (r_v[31:16] == 16'h0000)
      w_cls = c_cls_zer;
    else if (r_v[15:0] == 16'h0000)
      w_cls = c_cls_hip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= 32'h0;
      r_cnt <= '0;
    end else begin
      if (w_hs_in)
        r_v <= in_value;
      if (w_hs_out)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (w_hs_in)
          w_next_state = c_emit1;
      end
      c_emit1: begin
        if (w_hs_out)
          w_next_state = (w_cls == c_cls_two) ? c_emit2 : c_idle;
      end
      c_emit2: begin
        if (w_hs_out)
          w_next_state = c_idle;
      end
      default: w_next_state = c_idle;
    endcase
  end

  // Output words are decoded from the held value, so they stay stable under backpressure.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_imm16 = 16'h0000;
    out_extop = c_ext_zero;
    out_merge = 1'b0;
    out_last  = 1'b0;
    case (r_state)
      c_idle: begin
        in_ready = 1'b1;
      end
      c_emit1: begin
        out_valid = 1'b1;
        case (w_cls)
          c_cls_sgn: begin
            out_imm16 = r_v[15:0];
            out_extop = c_ext_sign;
            out_last  = 1'b1;
          end
          c_cls_zer: begin
            out_imm16 = r_v[15:0];
            out_extop = c_ext_zero;
            out_last  = 1'b1;
          end
          c_cls_hip: begin
            out_imm16 = r_v[31:16];
            out_extop = c_ext_high;
            out_last  = 1'b1;
          end
          default: begin
            out_imm16 = r_v[31:16];
            out_extop = c_ext_high;
          end
        endcase
      end
      c_emit2: begin
        out_valid = 1'b1;
        out_imm16 = r_v[15:0];
        out_extop = c_ext_zero;
        out_merge = 1'b1;
        out_last  = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
